// File: rtl/imem_pkg.sv
// Types and constants shared by the instruction-memory loader and the instruction memory.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 512;
  localparam int unsigned IMEM_ADDR_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StDone,
    StErr
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_t;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: the first byte lands in [7:0]; the finished
// word and a one-cycle word_ready pulse appear the cycle after the fourth byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx_q;
  logic [23:0] asm_q;
  logic [31:0] word_q;
  logic        ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      asm_q   <= 24'd0;
      word_q  <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (clear) begin
        idx_q <= 2'd0;
      end else if (byte_valid) begin
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // word_q only changes here, so the write data holds between writes
          word_q  <= {byte_data, asm_q};
          ready_q <= 1'b1;
        end else begin
          asm_q <= {byte_data, asm_q[23:8]};
        end
      end
    end
  end

  assign byte_idx   = idx_q;
  assign word       = word_q;
  assign word_ready = ready_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into the instruction memory while
// holding the CPU in reset; reports done or an error code when the load ends.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH       = IMEM_DEPTH,
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [15:0]      MAX_LEN  = 16'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);

  loader_state_t     state_q;
  err_code_t         err_code_q;
  logic              busy_q, done_q, err_q, cpu_rst_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   len_q;
  logic [7:0]        len_lo_q;
  logic [7:0]        sum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] addr_q;

  logic [15:0] len_in;
  logic        last_word;
  logic        pack_valid;
  logic        pack_clear;
  logic [1:0]  byte_idx;
  logic [31:0] pack_word;
  logic        word_ready;

  assign len_in     = {rx_data, len_lo_q};
  assign last_word  = (words_q == len_q - CNT_ONE);
  assign pack_valid = rx_valid && (state_q == StData);
  assign pack_clear = start && !busy_q;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word       (pack_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b0;
      words_q    <= '0;
      len_q      <= '0;
      len_lo_q   <= 8'd0;
      sum_q      <= 8'd0;
      tmo_q      <= '0;
      addr_q     <= '0;
    end else begin
      if (word_ready) words_q <= words_q + CNT_ONE;

      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q    <= StLenLo;
            busy_q     <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            words_q    <= '0;
            sum_q      <= 8'd0;
            tmo_q      <= '0;
          end
        end
        StLenLo: begin
          if (rx_valid) begin
            len_lo_q <= rx_data;
            state_q  <= StLenHi;
          end
        end
        StLenHi: begin
          if (rx_valid) begin
            if (len_in == 16'd0 || len_in > MAX_LEN) begin
              state_q    <= StErr;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
            end else begin
              len_q   <= len_in[ADDR_W:0];
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            sum_q <= sum_q + rx_data;
            if (byte_idx == 2'd3) begin
              // Earlier writes have retired by now, so words_q is this word's index.
              addr_q <= words_q[ADDR_W-1:0];
              if (last_word) state_q <= StCheck;
            end
          end
        end
        StCheck: begin
          if (rx_valid) begin
            if (rx_data == sum_q) begin
              state_q   <= StDone;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q    <= StErr;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_CHK;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Every busy state accepts bytes, so only silent cycles advance the timeout.
      if (busy_q) begin
        if (rx_valid) begin
          tmo_q <= '0;
        end else if (tmo_q == TMO_LAST) begin
          state_q    <= StErr;
          busy_q     <= 1'b0;
          err_q      <= 1'b1;
          err_code_q <= ERR_TMO;
        end else begin
          tmo_q <= tmo_q + TMO_ONE;
        end
      end
    end
  end

  assign mem_we       = word_ready;
  assign mem_addr     = addr_q;
  assign mem_wdata    = pack_word;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign cpu_rst      = cpu_rst_q;
  assign words_loaded = words_q;

endmodule
